// File: rtl/mu0_loader_pkg.sv
// Shared types and sizing constants for the MU0 program loader.
package mu0_loader_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned MAX_WORDS  = 2 ** ADDR_W_DEF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_CHK_HI,
    S_CHK_LO,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/mu0_loader_byte_pair.sv
// Joins a handshaken high byte and the following low byte into a 16-bit word.
module byte_pair (
  input  logic        sysclk,
  input  logic        ext_reset,
  input  logic        i_hs,
  input  logic        i_lo,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_word,
  output logic        o_word_rdy
);

  logic [7:0] r_hi;

  always_ff @(posedge sysclk or negedge ext_reset) begin
    if (!ext_reset) begin
      r_hi <= '0;
    end else if (i_hs && !i_lo) begin
      r_hi <= i_byte;
    end
  end

  // The word is presented combinationally on the low-byte handshake cycle.
  assign o_word     = {r_hi, i_byte};
  assign o_word_rdy = i_hs & i_lo;

endmodule

// File: rtl/mu0_loader.sv
// Receives a LEN/data/CHK byte frame and writes it into MU0 RAM, holding the core meanwhile.
module mu0_loader
  import mu0_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              sysclk,
  input  logic              ext_reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned L_MAX_WORDS = 2 ** ADDR_W;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [15:0]       r_len;
  logic [ADDR_W-1:0] r_index;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_word;
  logic [15:0]       r_acc;
  logic              w_hs;
  logic              w_lo;
  logic              w_idle_like;
  logic              w_last;
  logic              w_len_bad;
  logic [15:0]       w_word;
  logic              w_word_rdy;

  assign w_hs        = rx_valid & rx_ready;
  assign w_lo        = (r_state == S_LEN_LO) || (r_state == S_DATA_LO) || (r_state == S_CHK_LO);
  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
  assign w_last      = (32'(r_index) == (32'(r_len) - 32'd1));
  assign w_len_bad   = (w_word == 16'h0000) || (32'(w_word) > L_MAX_WORDS);

  byte_pair u_byte_pair (
    .sysclk     (sysclk),
    .ext_reset  (ext_reset),
    .i_hs       (w_hs),
    .i_lo       (w_lo),
    .i_byte     (rx_data),
    .o_word     (w_word),
    .o_word_rdy (w_word_rdy)
  );

  always_ff @(posedge sysclk or negedge ext_reset) begin
    if (!ext_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (start)      w_state_nxt = S_LEN_HI;
      S_LEN_HI:              if (w_hs)       w_state_nxt = S_LEN_LO;
      S_LEN_LO:              if (w_word_rdy) w_state_nxt = w_len_bad ? S_ERR : S_DATA_HI;
      S_DATA_HI:             if (w_hs)       w_state_nxt = S_DATA_LO;
      S_DATA_LO:             if (w_word_rdy) w_state_nxt = S_WRITE;
      S_WRITE:                               w_state_nxt = w_last ? S_CHK_HI : S_DATA_HI;
      S_CHK_HI:              if (w_hs)       w_state_nxt = S_CHK_LO;
      S_CHK_LO:              if (w_word_rdy) w_state_nxt = (w_word == r_acc) ? S_DONE : S_ERR;
      default:                               w_state_nxt = S_IDLE;
    endcase
  end

  // Address and data are latched on the low-byte handshake so they are stable
  // throughout WRITE and keep their value until the next word.
  always_ff @(posedge sysclk or negedge ext_reset) begin
    if (!ext_reset) begin
      r_len   <= '0;
      r_index <= '0;
      r_acc   <= '0;
      r_addr  <= '0;
      r_word  <= '0;
    end else begin
      if (w_idle_like && start) begin
        r_index <= '0;
        r_acc   <= '0;
      end
      if (r_state == S_LEN_LO && w_word_rdy) begin
        r_len <= w_word;
      end
      if (r_state == S_DATA_LO && w_word_rdy) begin
        r_addr <= r_index;
        r_word <= w_word;
      end
      if (r_state == S_WRITE) begin
        r_acc <= r_acc ^ r_word;
        if (!w_last) begin
          r_index <= r_index + 1'b1;
        end
      end
    end
  end

  assign rx_ready  = (r_state == S_LEN_HI)  || (r_state == S_LEN_LO) ||
                     (r_state == S_DATA_HI) || (r_state == S_DATA_LO) ||
                     (r_state == S_CHK_HI)  || (r_state == S_CHK_LO);
  assign mem_we    = (r_state == S_WRITE);
  assign mem_addr  = r_addr;
  assign mem_wdata = DATA_W'(r_word);
  assign busy      = !w_idle_like;
  assign done      = (r_state == S_DONE);
  assign err       = (r_state == S_ERR);
  assign cpu_hold  = (r_state != S_DONE);

endmodule

// File: tb/tb_mu0_loader.sv
// Scoreboard bench for mu0_loader: a frame model queues expected RAM writes, a monitor checks them.
module tb_mu0_loader;

  logic        sysclk    = 1'b0;
  logic        ext_reset = 1'b0;
  logic        start     = 1'b0;
  logic [7:0]  rx_data   = '0;
  logic        rx_valid  = 1'b0;
  logic        rx_ready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct {
    logic [11:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec   = 0;
  int  n_err   = 0;
  bit  prev_hs = 1'b0;
  bit  gaps_on = 1'b1;

  mu0_loader #(.ADDR_W(12), .DATA_W(16)) dut (
    .sysclk    (sysclk),
    .ext_reset (ext_reset),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge sysclk) begin
    wr_t e;
    if (ext_reset && mem_we) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.a));
        chk("wr_data", 32'(mem_wdata), 32'(e.d));
      end
      chk("ready_in_write", 32'(rx_ready), 32'd0);
      chk("write_latency", 32'(prev_hs), 32'd1);
    end
    prev_hs = rx_valid & rx_ready;
  end

  task automatic send_byte(input logic [7:0] b);
    int unsigned g;
    int unsigned t;
    if (gaps_on) begin
      g = $urandom_range(0, 3);
      repeat (g) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(posedge sysclk); #1;
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    start    = ($urandom_range(0, 7) == 0);
    for (t = 0; t < 64; t++) begin
      @(negedge sysclk);
      if (rx_ready) break;
    end
    if (!rx_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL byte_timeout: got rx_ready 0 expected 1 within 64 cycles");
    end
    @(posedge sysclk); #1;
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge sysclk); #1;
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_hold", 32'(cpu_hold), 32'd1);
    chk("start_done_clr", 32'(done), 32'd0);
    chk("start_err_clr", 32'(err), 32'd0);
  endtask

  task automatic wait_end();
    for (int t = 0; t < 32; t++) begin
      if (done || err) break;
      @(negedge sysclk);
    end
  endtask

  // Reference model: a frame is good iff 1 <= LEN <= 4096 and CHK equals the XOR of the words.
  task automatic run_frame(input logic [15:0] len, input logic [15:0] words[$], input logic [15:0] chkv);
    logic [15:0] x;
    bit          len_bad;
    bit          good;
    wr_t         w;
    len_bad = (len == 16'd0) || (int'(len) > 4096);
    x = '0;
    foreach (words[i]) x = x ^ words[i];
    good = !len_bad && (x == chkv);
    do_start();
    send_byte(len[15:8]);
    send_byte(len[7:0]);
    if (!len_bad) begin
      for (int i = 0; i < words.size(); i++) begin
        send_byte(words[i][15:8]);
        w.a = 12'(i);
        w.d = words[i];
        exp_q.push_back(w);
        send_byte(words[i][7:0]);
      end
      send_byte(chkv[15:8]);
      send_byte(chkv[7:0]);
    end
    wait_end();
    chk("end_done", 32'(done), 32'(good));
    chk("end_err", 32'(err), 32'(!good));
    chk("end_hold", 32'(cpu_hold), 32'(!good));
    chk("end_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge sysclk);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    @(posedge sysclk); #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ready"}, 32'(rx_ready), 32'd0);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
  endtask

  initial begin
    logic [15:0] q[$];
    wr_t         w;
    logic [15:0] x;
    int unsigned n;

    repeat (2) @(posedge sysclk);
    #1;
    reset_checks("rst");
    ext_reset = 1'b1;
    @(posedge sysclk); #1;

    q = {16'h1004, 16'h2005, 16'h7000};
    run_frame(16'h0003, q, 16'h4001);
    run_frame(16'h0003, q, 16'h4000);

    q.delete();
    run_frame(16'h0000, q, 16'h0000);
    run_frame(16'h1001, q, 16'h0000);

    for (int i = 0; i < 5; i++) q.push_back(16'($urandom));
    x = '0;
    foreach (q[i]) x = x ^ q[i];
    run_frame(16'd5, q, x);

    // Abandon a 4-word frame after two words have been written.
    q.delete();
    for (int i = 0; i < 4; i++) q.push_back(16'($urandom));
    do_start();
    send_byte(8'h00);
    send_byte(8'h04);
    for (int i = 0; i < 2; i++) begin
      send_byte(q[i][15:8]);
      w.a = 12'(i);
      w.d = q[i];
      exp_q.push_back(w);
      send_byte(q[i][7:0]);
    end
    repeat (2) @(posedge sysclk);
    #2;
    ext_reset = 1'b0;
    #1;
    reset_checks("midrst");
    chk("midrst_pending", 32'(exp_q.size()), 32'd0);
    @(posedge sysclk); #1;
    ext_reset = 1'b1;
    @(posedge sysclk); #1;
    x = '0;
    foreach (q[i]) x = x ^ q[i];
    run_frame(16'd4, q, x);

    for (int f = 0; f < 6; f++) begin
      q.delete();
      n = $urandom_range(1, 8);
      for (int i = 0; i < int'(n); i++) q.push_back(16'($urandom));
      x = '0;
      foreach (q[i]) x = x ^ q[i];
      if ($urandom_range(0, 3) == 0) x = x ^ 16'(1 << $urandom_range(0, 15));
      run_frame(16'(n), q, x);
    end

    gaps_on = 1'b0;
    q.delete();
    for (int i = 0; i < 4096; i++) q.push_back(16'(i));
    run_frame(16'd4096, q, 16'h0000);
    chk("full_last_addr", 32'(mem_addr), 32'h0FFF);
    chk("full_last_data", 32'(mem_wdata), 32'h0FFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
